retire_stage: RTL
=================

# retire_stage

Parametrised in-order commit stage between the ROB head window and the precise state: the architectural map table and the freelist. It retires up to `RETIRE_W` completed head entries per cycle and detects branch mispredicts at commit, driving recovery and a fetch redirect. A recovery/halt state machine blocks retirement while the pipeline drains. Same-cycle writes to one architectural register are collapsed so that the youngest write wins.

## Interface
- `RETIRE_W`, default `N`: head-window lanes examined per cycle; lane 0 is the oldest.
- `ARCH_COUNT`, default 32: architectural registers.
- `PHYS_REGS`, default `PHYS_REG_SZ_R10K`: physical registers; `PRW = $clog2(PHYS_REGS)`.
- `RECOVER_CYCLES`, default 2: cycles spent in RECOVER after a mispredict, minimum 1.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `head_entries` in `ROB_ENTRY[RETIRE_W]`: ROB head window.
- `head_valids` in `RETIRE_W`: per-lane occupancy.
- `stall` in 1: blocks all retirement this cycle.
- `rob_mispredict` out 1: flush request to the ROB.
- `rob_mispred_idx` out `ROB_IDX`: `rob_idx` of the mispredicted branch.
- `BPRecoverEN` out 1: restore the speculative map and freelist from precise state.
- `recover_pc` out `ADDR`: redirect target.
- `Arch_Retire_EN` out `RETIRE_W`: per-lane architectural map write enable.
- `Arch_Tnew_in` out `RETIRE_W×PRW`: `phys_rd` to write.
- `Arch_Retire_AR` out `RETIRE_W×5`: `arch_rd` to write.
- `FL_RetireEN` out `RETIRE_W`: per-lane freelist return enable.
- `FL_RetireReg` out `RETIRE_W×PRW`: `prev_phys_rd` to return.
- `retire_count` out `$clog2(RETIRE_W+1)`: number of lanes retired this cycle.
- `halted` out 1: sticky halt indication.
- `stat_retired` out 32: total instructions retired.
- `stat_mispred` out 32: total mispredicts.

## Operation
- Lane `k` is eligible when all of the following hold: state is RUN, `!stall`, `head_valids[k]`, `head_entries[k].complete`, and every lane `j<k` is eligible and is neither a mispredict nor a halt. Eligibility stops at the first lane that fails.
- A lane is a mispredict when it is a branch and either `branch_taken!=pred_taken`, or it is taken and `branch_target!=pred_target`.
- An eligible lane with `arch_rd!=0`:
  - raises `FL_RetireEN` with `prev_phys_rd`;
  - raises `Arch_Retire_EN` with `phys_rd`/`arch_rd`, unless a younger eligible lane in the same cycle has the same `arch_rd`. In that case only the youngest lane writes, but every lane still returns its Told.
- An eligible lane with `arch_rd==0` retires with no map or freelist traffic.
- Mispredict on eligible lane `k`:
  - lanes `<k` retire normally;
  - lane `k` retires (its dest is committed if it has one);
  - lanes `>k` are suppressed.
  - In the same cycle, assert `rob_mispredict`, `BPRecoverEN`, `rob_mispred_idx=rob_idx`, and `recover_pc = branch_taken ? branch_target : PC+4`.
  - The next state is RECOVER.
- Halt on eligible lane `k` (`halt`, `illegal`, or `exception!=NO_ERROR`): lane `k` retires, younger lanes are suppressed, and the next state is HALTED.
- If one lane is both a mispredict and a halt, halt wins: no recovery.
- State machine:
  - RUN: retires as above.
  - RECOVER: a counter loads `RECOVER_CYCLES-1`. Nothing retires and all outputs are idle. The state returns to RUN when the counter hits 0.
  - HALTED: terminal until `reset`; `halted=1` and nothing retires.

## Timing
- Commit, mispredict and redirect outputs are combinational from the head inputs in the cycle the entries become complete at the head. The FSM and counters update on `posedge clock`.
- A mispredict pulse lasts exactly 1 cycle. The earliest next retirement is `RECOVER_CYCLES+1` cycles after the detect cycle.
- `stall` has the same effect as no eligible lane: there is no partial retirement and no mispredict detection.
- Reset values:
  - state = RUN; counter = 0;
  - `halted=0`; `stat_*=0`;
  - every enable, `rob_mispredict` and `BPRecoverEN` = 0; index, PC and tag outputs = 0.
- Reset asserted in RECOVER or HALTED returns the block to RUN on the next edge, and no outputs are asserted during the reset cycle.
- `stat_retired` adds `retire_count` each cycle and wraps modulo 2^32.

## Configuration
- `RETIRE_STATS_EN`:
  - defined: `stat_retired` and `stat_mispred` count as described;
  - undefined: both ports remain and are tied to 0, and the counter registers are not built.

## Test plan
- Two ALU ops complete at the head: x5 (Tnew 40, Told 5) and x6 (Tnew 41, Told 6) -> `Arch_Retire_EN` and `FL_RetireEN` each have 2 bits set, the FL regs are {5,6}, and `retire_count=2`.
- Lanes 0 and 1 both write x7 (Tnew 42/43, Told 7/42) -> only lane 1 writes the arch map (Tnew 43), and the freelist receives {7,42}.
- Branch at the head, pred NT, resolved taken to 0x100, no dest -> `rob_mispredict=BPRecoverEN=1`, `recover_pc=0x100`, no Arch/FL enables; with `RECOVER_CYCLES=2`, the following complete entry retires 3 cycles later.
- Lane 0 complete, lane 1 incomplete, lane 2 complete -> only lane 0 retires; `stall=1` -> nothing retires.
- Halt at lane 1 with complete lanes 0-3 -> lanes 0-1 retire, `halted=1` and stays 1 with later complete entries; reset clears it.
- With `RETIRE_STATS_EN`, after the scenarios above -> `stat_mispred=1` and `stat_retired` equals the sum of `retire_count`; without it, both read 0.

Source files
------------

// File: rtl/retire_stage_if.sv
// Shared commit-stage types and the head-window / commit-bus interface of retire_stage.
package retire_pkg;
  localparam int N                = 4;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int ROB_SZ           = 32;

  typedef logic [$clog2(ROB_SZ)-1:0]           ROB_IDX;
  typedef logic [31:0]                         ADDR;
  typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PREG;

  typedef enum logic [3:0] {
    NO_ERROR           = 4'h0,
    INST_ADDR_MISALIGN = 4'h1,
    ILLEGAL_INST       = 4'h2,
    LOAD_FAULT         = 4'h5
  } EXCEPTION_CODE;

  typedef struct packed {
    logic          complete;
    ROB_IDX        rob_idx;
    ADDR           PC;
    logic [4:0]    arch_rd;
    PREG           phys_rd;
    PREG           prev_phys_rd;
    logic          is_branch;
    logic          branch_taken;
    logic          pred_taken;
    ADDR           branch_target;
    ADDR           pred_target;
    logic          halt;
    logic          illegal;
    EXCEPTION_CODE exception;
  } ROB_ENTRY;
endpackage

interface retire_stage_if #(
  parameter int RETIRE_W = retire_pkg::N,
  parameter int PRW      = $clog2(retire_pkg::PHYS_REG_SZ_R10K)
);
  localparam int CW = $clog2(RETIRE_W + 1);

  retire_pkg::ROB_ENTRY [RETIRE_W-1:0] head_entries;
  logic [RETIRE_W-1:0]                 head_valids;
  logic                                stall;

  logic                          rob_mispredict;
  retire_pkg::ROB_IDX            rob_mispred_idx;
  logic                          BPRecoverEN;
  retire_pkg::ADDR               recover_pc;
  logic [RETIRE_W-1:0]           Arch_Retire_EN;
  logic [RETIRE_W-1:0][PRW-1:0]  Arch_Tnew_in;
  logic [RETIRE_W-1:0][4:0]      Arch_Retire_AR;
  logic [RETIRE_W-1:0]           FL_RetireEN;
  logic [RETIRE_W-1:0][PRW-1:0]  FL_RetireReg;
  logic [CW-1:0]                 retire_count;
  logic                          halted;
  logic [31:0]                   stat_retired;
  logic [31:0]                   stat_mispred;

  modport master (
    output head_entries, head_valids, stall,
    input  rob_mispredict, rob_mispred_idx, BPRecoverEN, recover_pc,
           Arch_Retire_EN, Arch_Tnew_in, Arch_Retire_AR, FL_RetireEN, FL_RetireReg,
           retire_count, halted, stat_retired, stat_mispred
  );
  modport slave (
    input  head_entries, head_valids, stall,
    output rob_mispredict, rob_mispred_idx, BPRecoverEN, recover_pc,
           Arch_Retire_EN, Arch_Tnew_in, Arch_Retire_AR, FL_RetireEN, FL_RetireReg,
           retire_count, halted, stat_retired, stat_mispred
  );
endinterface

// File: rtl/retire_stage.sv
// In-order commit of up to RETIRE_W head entries, mispredict recovery and sticky halt.
// Define RETIRE_STATS_EN to build the stat_retired / stat_mispred counters (tied to 0 otherwise).
module retire_lane (
  input  logic                      valid,
  input  logic                      complete,
  input  logic                      is_branch,
  input  logic                      branch_taken,
  input  logic                      pred_taken,
  input  retire_pkg::ADDR           branch_target,
  input  retire_pkg::ADDR           pred_target,
  input  logic                      halt,
  input  logic                      illegal,
  input  retire_pkg::EXCEPTION_CODE exception,
  output logic                      ready,
  output logic                      mispred,
  output logic                      stop_halt
);
  assign ready     = valid && complete;
  assign mispred   = is_branch && ((branch_taken != pred_taken) ||
                                   (branch_taken && (branch_target != pred_target)));
  assign stop_halt = halt || illegal || (exception != retire_pkg::NO_ERROR);
endmodule

module retire_stage #(
  parameter int RETIRE_W       = retire_pkg::N,
  parameter int ARCH_COUNT     = 32,
  parameter int PHYS_REGS      = retire_pkg::PHYS_REG_SZ_R10K,
  parameter int RECOVER_CYCLES = 2
) (
  input logic           clock,
  input logic           reset,
  retire_stage_if.slave rif
);
  localparam int PRW   = $clog2(PHYS_REGS);
  localparam int ARW   = $clog2(ARCH_COUNT);
  localparam int CW    = $clog2(RETIRE_W + 1);
  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [RETIRE_W-1:0] ready, mp, hl, elig, arch_en, fl_en;
  logic                fire_mp, fire_halt, go;
  retire_pkg::ROB_ENTRY mp_e;
  logic [CW-1:0]       count;

  for (genvar g = 0; g < RETIRE_W; g++) begin : g_lane
    retire_lane u_lane (
      .valid        (rif.head_valids[g]),
      .complete     (rif.head_entries[g].complete),
      .is_branch    (rif.head_entries[g].is_branch),
      .branch_taken (rif.head_entries[g].branch_taken),
      .pred_taken   (rif.head_entries[g].pred_taken),
      .branch_target(rif.head_entries[g].branch_target),
      .pred_target  (rif.head_entries[g].pred_target),
      .halt         (rif.head_entries[g].halt),
      .illegal      (rif.head_entries[g].illegal),
      .exception    (rif.head_entries[g].exception),
      .ready        (ready[g]),
      .mispred      (mp[g]),
      .stop_halt    (hl[g])
    );
  end

  // Eligibility is a prefix: it ends at the first not-ready lane or just after a mispredict/halt lane.
  always_comb begin
    elig  = '0;
    count = '0;
    go    = (state == RUN) && !reset && !rif.stall;
    for (int k = 0; k < RETIRE_W; k++) begin
      elig[k] = go && ready[k];
      go      = elig[k] && !mp[k] && !hl[k];
      count   = count + CW'(elig[k]);
    end
  end

  // At most one eligible lane can stop the window; halt takes priority over mispredict.
  always_comb begin
    fire_mp   = 1'b0;
    fire_halt = 1'b0;
    mp_e      = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (elig[k] && hl[k]) fire_halt = 1'b1;
      else if (elig[k] && mp[k]) begin
        fire_mp = 1'b1;
        mp_e    = rif.head_entries[k];
      end
    end
  end

  // Every retiring dest returns its Told; only the youngest same-cycle writer of a register updates the map.
  always_comb begin
    arch_en = '0;
    fl_en   = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      fl_en[k]   = elig[k] && (rif.head_entries[k].arch_rd != 5'd0);
      arch_en[k] = fl_en[k];
      for (int j = k + 1; j < RETIRE_W; j++)
        if (elig[j] && (rif.head_entries[j].arch_rd[ARW-1:0] == rif.head_entries[k].arch_rd[ARW-1:0]))
          arch_en[k] = 1'b0;
    end
  end

  always_comb begin
    rif.Arch_Retire_EN = '0;
    rif.Arch_Tnew_in   = '0;
    rif.Arch_Retire_AR = '0;
    rif.FL_RetireEN    = '0;
    rif.FL_RetireReg   = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      if (fl_en[k]) begin
        rif.FL_RetireEN[k]  = 1'b1;
        rif.FL_RetireReg[k] = PRW'(rif.head_entries[k].prev_phys_rd);
      end
      if (arch_en[k]) begin
        rif.Arch_Retire_EN[k] = 1'b1;
        rif.Arch_Tnew_in[k]   = PRW'(rif.head_entries[k].phys_rd);
        rif.Arch_Retire_AR[k] = rif.head_entries[k].arch_rd;
      end
    end
  end

  assign rif.retire_count    = count;
  assign rif.rob_mispredict  = fire_mp;
  assign rif.BPRecoverEN     = fire_mp;
  assign rif.rob_mispred_idx = fire_mp ? mp_e.rob_idx : '0;
  assign rif.recover_pc      = !fire_mp ? '0 :
                               (mp_e.branch_taken ? mp_e.branch_target : mp_e.PC + 32'd4);
  assign rif.halted          = (state == HALTED) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (fire_halt) state_nx = HALTED;
        else if (fire_mp) begin
          state_nx = RECOVER;
          cnt_nx   = CNT_W'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (cnt == '0) state_nx = RUN;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

`ifdef RETIRE_STATS_EN
  logic [31:0] n_ret, n_mp;
  always_ff @(posedge clock) begin
    if (reset) begin
      n_ret <= '0;
      n_mp  <= '0;
    end else begin
      n_ret <= n_ret + 32'(count);
      n_mp  <= n_mp + 32'(fire_mp);
    end
  end
  assign rif.stat_retired = n_ret;
  assign rif.stat_mispred = n_mp;
`else
  assign rif.stat_retired = '0;
  assign rif.stat_mispred = '0;
`endif
endmodule
